// File: rtl/mdu_pkg.sv
//==============================================================================
// Module : mdu_pkg
// Brief  : Shared types and constants for the MDU issue/scoreboard logic.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETIRE = 2'd3
    } lop_state_t;

    localparam logic [4:0] REG_X0          = 5'd0;
    localparam int         DEFAULT_TIMEOUT = 64;

endpackage

`default_nettype wire

// File: rtl/longop_scoreboard.sv
//==============================================================================
// Module : longop_scoreboard
// Brief  : Single-entry MDU issue controller, hazard scoreboard and shared
//          register-file write-port arbiter.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module longop_scoreboard
    import mdu_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic        id_longop,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_regwrite,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        flush_d,
    output logic        mdu_start,
    input  logic        mdu_done,
    input  logic [31:0] mdu_result,
    input  logic        pipe_regwrite,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_result,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        stall_d,
    output logic        busy,
    output logic        err
);

    localparam int                c_WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    lop_state_t        r_state;
    logic [4:0]        r_pend_rd;
    logic [31:0]       r_res_q;
    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_mdu_start;
    logic              r_err;

    logic w_accept;
    logic w_busy;
    logic w_retire;
    logic w_pend_live;
    logic w_hazard;
    logic w_struct;

    assign w_accept    = id_valid && id_longop && !flush_d;
    assign w_busy      = (r_state != IDLE);
    assign w_retire    = (r_state == RETIRE);
    assign w_pend_live = w_busy && (r_pend_rd != REG_X0);

    // A pending x0 destination never blocks readers or writers of x0.
    assign w_hazard = w_pend_live && id_valid &&
                      ((id_uses_rs1 && (id_rs1 == r_pend_rd)) ||
                       (id_uses_rs2 && (id_rs2 == r_pend_rd)) ||
                       (id_regwrite && (id_rd  == r_pend_rd)));
    assign w_struct = id_valid && id_longop && w_busy;

    assign stall_d = !flush_d && (w_hazard || w_struct || w_retire);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pend_rd   <= REG_X0;
            r_res_q     <= 32'd0;
            r_wd_cnt    <= '0;
            r_mdu_start <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mdu_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state     <= ISSUE;
                        r_pend_rd   <= id_rd;
                        r_mdu_start <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (mdu_done) begin
                        r_res_q <= mdu_result;
                        r_state <= (r_pend_rd == REG_X0) ? IDLE : RETIRE;
                    end else begin
                        r_state  <= WAIT;
                        r_wd_cnt <= '0;
                    end
                end
                WAIT: begin
                    // A done arriving on the final watchdog cycle still wins.
                    if (mdu_done) begin
                        r_res_q <= mdu_result;
                        r_state <= (r_pend_rd == REG_X0) ? IDLE : RETIRE;
                    end else if (r_wd_cnt == c_WD_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                RETIRE: begin
                    if (!pipe_regwrite) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // WB traffic owns the port; the MDU result slips in on the first free cycle.
    assign rf_we = pipe_regwrite | (w_retire & !pipe_regwrite);
    assign rf_wa = pipe_regwrite ? pipe_rd     : r_pend_rd;
    assign rf_wd = pipe_regwrite ? pipe_result : r_res_q;

    assign mdu_start = r_mdu_start;
    assign busy      = w_busy;
    assign err       = r_err;

endmodule

`default_nettype wire
